// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared constants, status bit map and TX sequencer states for uart_mmio_ctrl.
package uart_mmio_ctrl_pkg;

  localparam logic [31:0] UART_ADDR_DEF   = 32'h0000_0404;
  localparam logic [31:0] STATUS_ADDR_DEF = 32'h0000_0408;

  localparam int unsigned STATUS_W       = 5;
  localparam int unsigned STAT_RX_EMPTY  = 0;
  localparam int unsigned STAT_TX_FULL   = 1;
  localparam int unsigned STAT_TX_IDLE   = 2;
  localparam int unsigned STAT_TX_DROP   = 3;
  localparam int unsigned STAT_RX_OVERRUN = 4;

  localparam logic [31:0] RX_EMPTY_VAL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// Single-clock FIFO with a combinational head; pointers carry an extra wrap bit.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop & ~empty_c;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push & (~full_c | do_pop);
  assign head_c  = mem[rd_ptr[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: address decode, TX/RX FIFOs, TX core sequencer.
// Optional status register enabled by defining UART_STATUS_REG_EN.
module uart_mmio_ctrl
  import uart_mmio_ctrl_pkg::*;
#(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] UART_ADDR   = WIDTH'(UART_ADDR_DEF),
  parameter logic [WIDTH-1:0] STATUS_ADDR = WIDTH'(STATUS_ADDR_DEF),
  parameter int unsigned     FIFO_DEPTH  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] MEMORY_ADDR,
  input  logic [7:0]       UART_TRANSMIT_DATA,
  input  logic             MemWrite,
  input  logic             MemRead,
  output logic             SELECT_UART,
  output logic [WIDTH-1:0] UART_RECIEVE_DATA,
  output logic             MemWrite_DATA,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_busy,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid
);

  tx_state_e           state;
  tx_state_e           state_nx;
  logic                tx_pop;
  logic                tx_start_nx;
  logic [7:0]          tx_head;
  logic [7:0]          rx_head;
  logic                tx_full;
  logic                tx_empty;
  logic                rx_full;
  logic                rx_empty;
  logic                tx_drop;
  logic                rx_overrun;
  logic                sel_data_c;
  logic                sel_status_c;
  logic                tx_push;
  logic                rx_pop;
  logic                status_rd;
  logic [STATUS_W-1:0] status_c;

  assign sel_data_c = (MEMORY_ADDR == UART_ADDR);
`ifdef UART_STATUS_REG_EN
  assign sel_status_c = (MEMORY_ADDR == STATUS_ADDR);
`else
  assign sel_status_c = 1'b0;
  logic unused_c;
  assign unused_c = ^{status_c, STATUS_ADDR};
`endif

  assign SELECT_UART   = sel_data_c | sel_status_c;
  assign MemWrite_DATA = MemWrite & ~SELECT_UART;
  assign tx_push       = MemWrite & sel_data_c;
  assign rx_pop        = MemRead & sel_data_c & ~rx_empty;
  assign status_rd     = MemRead & sel_status_c;

  // Status word assembly.
  always_comb begin
    status_c                  = '0;
    status_c[STAT_RX_EMPTY]   = rx_empty;
    status_c[STAT_TX_FULL]    = tx_full;
    status_c[STAT_TX_IDLE]    = (state == ST_IDLE) & tx_empty;
    status_c[STAT_TX_DROP]    = tx_drop;
    status_c[STAT_RX_OVERRUN] = rx_overrun;
  end

  // Load data mux; the RX head is visible in the same cycle it is popped.
  always_comb begin
    UART_RECIEVE_DATA = '0;
    if (sel_data_c) begin
      UART_RECIEVE_DATA = rx_empty ? WIDTH'(RX_EMPTY_VAL) : WIDTH'(rx_head);
    end else if (sel_status_c) begin
      UART_RECIEVE_DATA = WIDTH'(status_c);
    end
  end

  // Sticky drop/overrun flags; a new set wins over a status-read clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_drop    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      tx_drop    <= (tx_push & tx_full & ~tx_pop) | (tx_drop & ~status_rd);
      rx_overrun <= (rx_valid & rx_full & ~rx_pop) | (rx_overrun & ~status_rd);
    end
  end

  // TX sequencer next state: pop a byte, pulse start, wait for busy to rise then fall.
  always_comb begin
    state_nx = state;
    tx_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!tx_empty) begin
          tx_pop   = 1'b1;
          state_nx = ST_START;
        end
      end
      ST_START:     state_nx = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (tx_busy)  state_nx = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
    tx_start_nx = (state_nx == ST_START);
  end

  // TX sequencer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      state    <= state_nx;
      tx_start <= tx_start_nx;
      if (tx_pop) tx_data <= tx_head;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (UART_TRANSMIT_DATA),
    .pop       (tx_pop),
    .head_c    (tx_head),
    .full_c    (tx_full),
    .empty_c   (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head_c    (rx_head),
    .full_c    (rx_full),
    .empty_c   (rx_empty)
  );

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Randomised bench for uart_mmio_ctrl against a queue-based behavioural model.
module tb_uart_mmio_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] UA = 32'h0000_0404;
  localparam logic [31:0] SA = 32'h0000_0408;
`ifdef UART_STATUS_REG_EN
  localparam bit STATUS_EN = 1'b1;
`else
  localparam bit STATUS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] MEMORY_ADDR = '0;
  logic [7:0]  UART_TRANSMIT_DATA = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic        SELECT_UART;
  logic [31:0] UART_RECIEVE_DATA;
  logic        MemWrite_DATA;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;

  always #5 clk = ~clk;

  uart_mmio_ctrl dut (
    .clk                (clk),
    .reset              (reset),
    .MEMORY_ADDR        (MEMORY_ADDR),
    .UART_TRANSMIT_DATA (UART_TRANSMIT_DATA),
    .MemWrite           (MemWrite),
    .MemRead            (MemRead),
    .SELECT_UART        (SELECT_UART),
    .UART_RECIEVE_DATA  (UART_RECIEVE_DATA),
    .MemWrite_DATA      (MemWrite_DATA),
    .tx_data            (tx_data),
    .tx_start           (tx_start),
    .tx_busy            (tx_busy),
    .rx_data            (rx_data),
    .rx_valid           (rx_valid)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: FIFO contents as queues plus a "transmitter engaged" view.
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  bit         eng_free = 1'b1;
  bit         seen_busy = 1'b0;
  bit         m_start = 1'b0;
  bit         m_drop = 1'b0;
  bit         m_ovr = 1'b0;
  logic [7:0] m_txd = '0;

  // TX core responder: busy rises 2 cycles after start and stays high core_hold cycles.
  int core_dly = 0;
  int core_cnt = 0;
  int core_hold = 10;
  bit core_stuck = 1'b0;

  logic [31:0] obs_rdata;
  logic        obs_sel;
  logic        obs_mwd;
  int          n_starts = 0;

  task automatic step(input logic [31:0] addr, input logic we, input logic re,
                      input logic [7:0] wd, input logic rv, input logic [7:0] rd);
    bit sel_d;
    bit sel_s;
    bit pop_now;
    logic [4:0] st;
    MEMORY_ADDR = addr; MemWrite = we; MemRead = re;
    UART_TRANSMIT_DATA = wd; rx_valid = rv; rx_data = rd;
    @(negedge clk);
    sel_d = (addr == UA);
    sel_s = STATUS_EN && (addr == SA);
    st = {m_ovr, m_drop, eng_free && (txq.size() == 0), txq.size() == DEPTH, rxq.size() == 0};
    obs_sel = SELECT_UART; obs_mwd = MemWrite_DATA; obs_rdata = UART_RECIEVE_DATA;
    check("select", 32'(SELECT_UART), 32'(sel_d || sel_s));
    check("mem_we", 32'(MemWrite_DATA), 32'(we && !(sel_d || sel_s)));
    if (sel_d) check("rd_data", obs_rdata, (rxq.size() != 0) ? {24'h0, rxq[0]} : 32'hFFFF_FFFF);
    else if (sel_s) check("rd_status", obs_rdata, {27'h0, st});
    check("tx_start", 32'(tx_start), 32'(m_start));
    check("tx_data", 32'(tx_data), 32'(m_txd));
    if (tx_start) begin n_starts++; core_dly = 2; end
    // model the clock edge
    if (sel_s && re) begin m_drop = 1'b0; m_ovr = 1'b0; end
    if (sel_d && re && rxq.size() != 0) void'(rxq.pop_front());
    if (rv) begin
      if (rxq.size() < DEPTH) rxq.push_back(rd);
      else m_ovr = 1'b1;
    end
    pop_now = eng_free && (txq.size() != 0);
    if (!eng_free && !m_start) begin
      if (!seen_busy) seen_busy = tx_busy;
      else if (!tx_busy) begin eng_free = 1'b1; seen_busy = 1'b0; end
    end
    m_start = pop_now;
    if (pop_now) begin m_txd = txq.pop_front(); eng_free = 1'b0; end
    if (sel_d && we) begin
      if (txq.size() < DEPTH) txq.push_back(wd);
      else m_drop = 1'b1;
    end
    @(posedge clk); #1;
    if (core_dly > 0) begin
      core_dly--;
      if (core_dly == 0) begin tx_busy = 1'b1; core_cnt = core_hold; end
    end else if (tx_busy && !core_stuck) begin
      core_cnt--;
      if (core_cnt <= 0) tx_busy = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (!(eng_free && txq.size() == 0 && !tx_busy) && n < 600) begin
      step(32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0);
      n++;
    end
    check(tag, 32'(n < 600), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    txq.delete(); rxq.delete();
    eng_free = 1'b1; seen_busy = 1'b0; m_start = 1'b0;
    m_drop = 1'b0; m_ovr = 1'b0; m_txd = '0;
    core_dly = 0; core_cnt = 0; core_stuck = 1'b0; tx_busy = 1'b0;
    MemWrite = 1'b0; MemRead = 1'b0; rx_valid = 1'b0; MEMORY_ADDR = '0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned r;
    logic [31:0] a;
    int n;
    #12;
    do_reset();

    // empty receive read
    step(UA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("lw_empty_sel", 32'(obs_sel), 32'd1);
    check("lw_empty_data", obs_rdata, 32'hFFFF_FFFF);
`ifdef UART_STATUS_REG_EN
    step(SA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("status_after_reset", obs_rdata, 32'h0000_0005);
`endif

    // single transmit
    core_hold = 10; n_starts = 0;
    step(UA, 1'b1, 1'b0, 8'h41, 1'b0, 8'h0);
    check("sb_mem_we", 32'(obs_mwd), 32'd0);
    drain("drain_41");
    check("one_start", 32'(n_starts), 32'd1);
    check("tx_41", 32'(tx_data), 32'h41);

    // fill TX FIFO behind a stalled transmitter, then overflow it
    core_stuck = 1'b1; n_starts = 0;
    for (int i = 1; i <= 9; i++) step(UA, 1'b1, 1'b0, 8'(i), 1'b0, 8'h0);
    check("first_popped", 32'(tx_data), 32'h01);
`ifdef UART_STATUS_REG_EN
    step(SA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("no_drop_yet", 32'(obs_rdata[3]), 32'd0);
    check("tx_full_bit", 32'(obs_rdata[1]), 32'd1);
`endif
    step(UA, 1'b1, 1'b0, 8'h0A, 1'b0, 8'h0);
`ifdef UART_STATUS_REG_EN
    step(SA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("drop_bit", 32'(obs_rdata[3]), 32'd1);
    step(SA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("drop_cleared", 32'(obs_rdata[3]), 32'd0);
`endif
    core_stuck = 1'b0;
    drain("drain_fill");
    check("nine_sent", 32'(n_starts), 32'd9);
    check("last_sent", 32'(tx_data), 32'h09);

    // single receive
    step(32'h0, 1'b0, 1'b0, 8'h0, 1'b1, 8'h5A);
    step(UA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("rx_5a", obs_rdata, 32'h0000_005A);
    step(UA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("rx_then_empty", obs_rdata, 32'hFFFF_FFFF);

    // full RX FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(32'h0, 1'b0, 1'b0, 8'h0, 1'b1, 8'(8'h10 + i));
    step(UA, 1'b0, 1'b1, 8'h0, 1'b1, 8'hA5);
    check("full_pop_head", obs_rdata, 32'h0000_0010);
    for (int i = 0; i < 8; i++) step(UA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("full_push_kept", obs_rdata, 32'h0000_00A5);
`ifdef UART_STATUS_REG_EN
    step(SA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("no_overrun", 32'(obs_rdata[4]), 32'd0);
`endif

    // RX overrun: ninth byte into a full FIFO is lost
    for (int i = 0; i < 9; i++) step(32'h0, 1'b0, 1'b0, 8'h0, 1'b1, 8'(8'h20 + i));
`ifdef UART_STATUS_REG_EN
    step(SA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("overrun_bit", 32'(obs_rdata[4]), 32'd1);
`endif
    for (int i = 0; i < 8; i++) step(UA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("overrun_last", obs_rdata, 32'h0000_0027);
    step(UA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("overrun_empty", obs_rdata, 32'hFFFF_FFFF);

    // non-UART store and status address decode
    step(32'h100, 1'b1, 1'b0, 8'h77, 1'b0, 8'h0);
    check("mem_sel", 32'(obs_sel), 32'd0);
    check("mem_we_pass", 32'(obs_mwd), 32'd1);
    step(SA, 1'b1, 1'b0, 8'h66, 1'b0, 8'h0);
    check("status_sel", 32'(obs_sel), 32'(STATUS_EN));
    idle(4);

    // reset while tx_start is high
    step(UA, 1'b1, 1'b0, 8'h33, 1'b0, 8'h0);
    step(32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 8'h0);
    check("pre_rst_start", 32'(tx_start), 32'd1);
    do_reset();
    idle(4);

    // reset while waiting for the transmitter to finish, with bytes queued
    core_hold = 10;
    step(UA, 1'b1, 1'b0, 8'h44, 1'b0, 8'h0);
    step(UA, 1'b1, 1'b0, 8'h45, 1'b0, 8'h0);
    step(UA, 1'b1, 1'b0, 8'h46, 1'b0, 8'h0);
    n = 0;
    while (!seen_busy && n < 50) begin idle(1); n++; end
    check("reach_wait_done", 32'(n < 50), 32'd1);
    idle(2);
    do_reset();
    n_starts = 0;
    idle(10);
    check("no_start_after_rst", 32'(n_starts), 32'd0);
`ifdef UART_STATUS_REG_EN
    step(SA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("status_post_rst", obs_rdata, 32'h0000_0005);
`endif
    step(UA, 1'b0, 1'b1, 8'h0, 1'b0, 8'h0);
    check("rx_lost_on_rst", obs_rdata, 32'hFFFF_FFFF);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      a = (r < 5) ? UA : ((r < 7) ? SA : 32'h100 + 32'($urandom_range(0, 15)) * 4);
      core_hold = $urandom_range(1, 6);
      step(a, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 8'($urandom),
           $urandom_range(0, 2) == 0, 8'($urandom));
    end
    drain("rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Memory-mapped UART controller placed between the single-cycle datapath's data-memory port and the UART TX/RX cores. It decodes UART addresses and produces SELECT_UART, UART_RECIEVE_DATA and a gated data-memory write enable. It buffers transmit bytes and received bytes in two FIFOs. A small FSM sequences the TX core handshake, so stores to the UART never stall the CPU.

Parameters:
WIDTH, 32, datapath word width
UART_ADDR, 32'h0000_0404, data register address (sb = transmit, lw = receive)
STATUS_ADDR, 32'h0000_0408, status register address (only used with the optional feature)
FIFO_DEPTH, 8, entries per FIFO; must be a power of 2 and at least 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
MEMORY_ADDR  in  WIDTH  datapath ALUResult
UART_TRANSMIT_DATA  in  8  datapath WriteData[7:0]
MemWrite  in  1  datapath store enable
MemRead  in  1  datapath load enable (ResultSrc selects memory)
SELECT_UART  out  1  address hits a UART register
UART_RECIEVE_DATA  out  WIDTH  load data for UART addresses
MemWrite_DATA  out  1  MemWrite & ~SELECT_UART, drives the data memory
tx_data  out  8  byte presented to the TX core
tx_start  out  1  one-cycle start pulse to the TX core
tx_busy  in  1  TX core is shifting
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe: rx_data is valid

Behaviour:
- Reset (reset=0, asynchronous):
  - both FIFOs empty; TX FSM in IDLE
  - tx_start=0, tx_data=0
  - sticky flags tx_drop and rx_overrun = 0
- SELECT_UART is combinational: (MEMORY_ADDR==UART_ADDR), OR'd with (MEMORY_ADDR==STATUS_ADDR) when the feature is on.
- Read path:
  - UART_RECIEVE_DATA is combinational.
  - At UART_ADDR: {24'h0, rx head} if the RX FIFO is non-empty, else 32'hFFFF_FFFF.
- RX pop: at the clk edge when MemRead & addr==UART_ADDR & RX FIFO non-empty. Zero added latency: the byte is seen in the same cycle as the load.
- TX push: at the clk edge when MemWrite & addr==UART_ADDR.
  - TX FIFO full: byte dropped, tx_drop set.
  - Stores to STATUS_ADDR are ignored.
- RX push: rx_valid & RX FIFO not full pushes rx_data. rx_valid while full drops the byte and sets rx_overrun.
- Simultaneous events:
  - Push and pop in the same cycle on a non-empty, non-full FIFO: both happen, count unchanged.
  - Push+pop on a full FIFO: the pop frees the slot, so the push is accepted and no flag is set.
  - Load from an empty RX FIFO while rx_valid is high: the load returns FFFF_FFFF, the byte is pushed, nothing is popped.
- FIFO pointers are log2(FIFO_DEPTH) bits with an extra wrap bit. Full = addresses equal, wrap bits differ. Empty = pointers equal.
- TX FSM:
  - IDLE: if TX FIFO non-empty, pop the head into tx_data and go to START.
  - START: tx_start=1 for exactly one cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_busy=0, then go to IDLE.
  - tx_data holds its value from START through WAIT_DONE.
  - Back-to-back bytes: at least 1 idle cycle between tx_busy falling and the next tx_start.
- Reset asserted mid-transfer: FSM returns to IDLE, FIFO contents are lost, tx_start drops immediately.

Optional Feature:
UART_STATUS_REG_EN
- Defined:
  - a load at STATUS_ADDR returns {27'h0, rx_overrun, tx_drop, tx_idle, tx_full, rx_empty} in bits [4:0].
  - a load at STATUS_ADDR clears both sticky flags at that clk edge.
  - a set condition in the same cycle as the clear wins (flag stays 1).
  - tx_idle = FSM in IDLE & TX FIFO empty.
- Undefined: no status decode and the flags are not readable. STATUS_ADDR accesses go to the data memory (SELECT_UART=0).

Decomposition:
- Shared package holds:
  - UART_ADDR and STATUS_ADDR defaults
  - status bit indices (RX_EMPTY=0, TX_FULL=1, TX_IDLE=2, TX_DROP=3, RX_OVERRUN=4)
  - the TX FSM state encoding (IDLE, START, WAIT_BUSY, WAIT_DONE)
  - the RX-empty read value 32'hFFFF_FFFF
- One sub-module, sync_fifo (params WIDTH=8, DEPTH), instantiated twice: TX and RX.

Test Plan:
- Reset, then a lw from 0x404 -> SELECT_UART=1, UART_RECIEVE_DATA=32'hFFFF_FFFF, no pop.
- sb 8'h41 to 0x404 with the TX model asserting tx_busy 2 cycles after start and holding it 10 cycles -> MemWrite_DATA=0; tx_start pulses once; tx_data=8'h41; FSM back in IDLE 1 cycle after tx_busy falls.
- 9 sb writes (8'h01..8'h09) with tx_busy held high -> 8'h01 is popped into tx_data; 8'h02..8'h09 fill the FIFO; all 9 accepted, tx_drop=0. A 10th write is dropped: tx_drop=1, status bit 3 reads 1.
- rx_valid with 8'h5A, then lw 0x404 -> returns 32'h0000_005A. The next lw returns 32'hFFFF_FFFF.
- RX FIFO full plus rx_valid in the same cycle as a lw at 0x404 -> the head is returned, the new byte is accepted, rx_overrun=0.
- sw to 0x100 -> SELECT_UART=0, MemWrite_DATA=1, UART state unchanged. Assert reset during WAIT_DONE -> tx_start=0, FSM in IDLE, status=32'h0000_0005.
